// File: rtl/window_3x3_gen_pkg.sv
// Shared accelerator package: frame geometry defaults, index width and the
// window generator FSM encoding. Imported by the padding stages and by the
// 3x3 window generator.
package window_3x3_gen_pkg;

  localparam int IMG_W_DEF = 416;
  localparam int IMG_H_DEF = 416;
  localparam int DW_DEF    = 8;

  // Column/row index width; covers frames up to 512 pixels on a side.
  localparam int IDX_W = 9;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } win_state_e;

  // Increment with wrap to zero after the terminal value.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v,
                                                input logic [IDX_W-1:0] last);
    return (v == last) ? '0 : v + IDX_W'(1);
  endfunction

endpackage

// File: rtl/window_3x3_gen_win_row_shift.sv
// win_row_shift: holds one padded row of NPIX pixels.
//   clk, rst : clock and synchronous active-high reset (clears the row)
//   load     : capture a new padded row from 'row'
//   shift    : advance one pixel (row moves right by DW, pixel p -> p-1)
//   row      : padded row input, pixel p at bits [DW*p +: DW]
//   taps     : the three lowest pixels, tap j at bits [DW*j +: DW]
module win_row_shift
  import window_3x3_gen_pkg::*;
#(
  parameter int NPIX = IMG_W_DEF + 2,
  parameter int DW   = DW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 shift,
  input  logic [NPIX*DW-1:0]   row,
  output logic [3*DW-1:0]      taps
);

  logic [NPIX*DW-1:0] data;

  // Load has priority so a capture always starts from a fresh row.
  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
    end else if (load) begin
      data <= row;
    end else if (shift) begin
      data <= {{DW{1'b0}}, data[NPIX*DW-1:DW]};
    end
  end

  assign taps = data[3*DW-1:0];

endmodule

// File: rtl/window_3x3_gen.sv
// window_3x3_gen: turns a set of three padded rows per colour channel into a
// stream of IMG_W 3x3 windows, one per output column.
//   clk, rst                : clock, synchronous active-high reset
//   {R,G,B}_row{0,1,2}      : padded rows, pixel p at bits [DW*p +: DW]
//   row_valid / row_ready   : row-set handshake (ready only while IDLE)
//   win_{R,G,B}             : window, byte 3*r+j = row r, column col+j
//   win_valid / win_ready   : window handshake
//   win_col, win_row        : output column / row index of the window
//   win_last, frame_last    : last window of the row / of the frame
module window_3x3_gen
  import window_3x3_gen_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [(IMG_W+2)*DW-1:0] R_row0,
  input  logic [(IMG_W+2)*DW-1:0] G_row0,
  input  logic [(IMG_W+2)*DW-1:0] B_row0,
  input  logic [(IMG_W+2)*DW-1:0] R_row1,
  input  logic [(IMG_W+2)*DW-1:0] G_row1,
  input  logic [(IMG_W+2)*DW-1:0] B_row1,
  input  logic [(IMG_W+2)*DW-1:0] R_row2,
  input  logic [(IMG_W+2)*DW-1:0] G_row2,
  input  logic [(IMG_W+2)*DW-1:0] B_row2,
  input  logic                    row_valid,
  output logic                    row_ready,
  output logic [9*DW-1:0]         win_R,
  output logic [9*DW-1:0]         win_G,
  output logic [9*DW-1:0]         win_B,
  output logic                    win_valid,
  input  logic                    win_ready,
  output logic [IDX_W-1:0]        win_col,
  output logic [IDX_W-1:0]        win_row,
  output logic                    win_last,
  output logic                    frame_last
);

  localparam int NPIX = IMG_W + 2;
  localparam int RW   = NPIX * DW;
  localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(IMG_W - 1);
  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(IMG_H - 1);

  win_state_e       state, state_nxt;
  logic [IDX_W-1:0] col, row;
  logic             capture, advance;

  // [channel][row] : channel 0 = R, 1 = G, 2 = B
  logic [RW-1:0]    rows_in [3][3];
  logic [3*DW-1:0]  taps    [3][3];

  assign rows_in[0][0] = R_row0;
  assign rows_in[0][1] = R_row1;
  assign rows_in[0][2] = R_row2;
  assign rows_in[1][0] = G_row0;
  assign rows_in[1][1] = G_row1;
  assign rows_in[1][2] = G_row2;
  assign rows_in[2][0] = B_row0;
  assign rows_in[2][1] = B_row1;
  assign rows_in[2][2] = B_row2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // row_ready is masked by rst so no handshake is signalled while the block
  // is being reset.
  always_comb begin
    state_nxt = state;
    row_ready = 1'b0;
    win_valid = 1'b0;
    capture   = 1'b0;
    advance   = 1'b0;
    case (state)
      IDLE: begin
        row_ready = !rst;
        if (row_valid && !rst) begin
          capture   = 1'b1;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        win_valid = 1'b1;
        if (win_ready) begin
          advance = 1'b1;
          if (col == LAST_COL) begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // col returns to 0 after the last window, so win_last cannot linger in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (capture) begin
      col <= '0;
    end else if (advance) begin
      col <= wrap_inc(col, LAST_COL);
      if (col == LAST_COL) begin
        row <= wrap_inc(row, LAST_ROW);
      end
    end
  end

  for (genvar ch = 0; ch < 3; ch++) begin : g_ch
    for (genvar r = 0; r < 3; r++) begin : g_row
      win_row_shift #(
        .NPIX (NPIX),
        .DW   (DW)
      ) u_shift (
        .clk   (clk),
        .rst   (rst),
        .load  (capture),
        .shift (advance),
        .row   (rows_in[ch][r]),
        .taps  (taps[ch][r])
      );
    end
  end

  assign win_R = {taps[0][2], taps[0][1], taps[0][0]};
  assign win_G = {taps[1][2], taps[1][1], taps[1][0]};
  assign win_B = {taps[2][2], taps[2][1], taps[2][0]};

  assign win_col    = col;
  assign win_row    = row;
  assign win_last   = win_valid && (col == LAST_COL);
  assign frame_last = win_last && (row == LAST_ROW);

endmodule

// File: tb/tb_window_3x3_gen.sv
// Bench for window_3x3_gen: a default-size instance driven row set by row set
// with a scoreboard of expected windows, plus an 8x4 instance for frame wrap.
module tb_window_3x3_gen;

  localparam int W  = 416;
  localparam int H  = 416;
  localparam int BW = (W + 2) * 8;
  localparam int SW = 8;
  localparam int SH = 4;
  localparam int SBW = (SW + 2) * 8;
  localparam logic [71:0] COL5_R = {8'd9, 8'd8, 8'd7, 8'd8, 8'd7, 8'd6, 8'd7, 8'd6, 8'd5};

  typedef struct packed {
    logic [8:0]  col;
    logic [8:0]  row;
    logic [71:0] r;
    logic [71:0] g;
    logic [71:0] b;
    logic        last;
    logic        fl;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [BW-1:0] R_row0, G_row0, B_row0, R_row1, G_row1, B_row1, R_row2, G_row2, B_row2;
  logic          row_valid, row_ready, win_valid, win_ready, win_last, frame_last;
  logic [71:0]   win_R, win_G, win_B;
  logic [8:0]    win_col, win_row;

  logic [SBW-1:0] s_R_row0, s_G_row0, s_B_row0, s_R_row1, s_G_row1, s_B_row1, s_R_row2, s_G_row2, s_B_row2;
  logic           s_row_valid, s_row_ready, s_win_valid, s_win_ready, s_win_last, s_frame_last;
  logic [71:0]    s_win_R, s_win_G, s_win_B;
  logic [8:0]     s_win_col, s_win_row;

  int   tests = 0;
  int   fails = 0;
  int   exp_row = 0;
  exp_t sb[$];

  window_3x3_gen dut (
    .clk(clk), .rst(rst),
    .R_row0(R_row0), .G_row0(G_row0), .B_row0(B_row0),
    .R_row1(R_row1), .G_row1(G_row1), .B_row1(B_row1),
    .R_row2(R_row2), .G_row2(G_row2), .B_row2(B_row2),
    .row_valid(row_valid), .row_ready(row_ready),
    .win_R(win_R), .win_G(win_G), .win_B(win_B),
    .win_valid(win_valid), .win_ready(win_ready),
    .win_col(win_col), .win_row(win_row),
    .win_last(win_last), .frame_last(frame_last)
  );

  window_3x3_gen #(.IMG_W(SW), .IMG_H(SH), .DW(8)) dut_s (
    .clk(clk), .rst(rst),
    .R_row0(s_R_row0), .G_row0(s_G_row0), .B_row0(s_B_row0),
    .R_row1(s_R_row1), .G_row1(s_G_row1), .B_row1(s_B_row1),
    .R_row2(s_R_row2), .G_row2(s_G_row2), .B_row2(s_B_row2),
    .row_valid(s_row_valid), .row_ready(s_row_ready),
    .win_R(s_win_R), .win_G(s_win_G), .win_B(s_win_B),
    .win_valid(s_win_valid), .win_ready(s_win_ready),
    .win_col(s_win_col), .win_row(s_win_row),
    .win_last(s_win_last), .frame_last(s_frame_last)
  );

  // Pixel model: seed 0 gives the plain ramp (p + r) on R.
  function automatic logic [7:0] pv(input int ch, input int r, input int p, input int seed);
    int x;
    case (ch)
      0:       x = (seed == 0) ? p + r : p * 7 + r * 31 + seed * 13;
      1:       x = p * 3 + r + 17 + seed;
      default: x = 255 - p - r * 5 + seed * 41;
    endcase
    return x[7:0];
  endfunction

  function automatic logic [BW-1:0] mk_row(input int ch, input int r, input int seed);
    logic [BW-1:0] v;
    for (int p = 0; p < W + 2; p++) v[p*8 +: 8] = pv(ch, r, p, seed);
    return v;
  endfunction

  function automatic logic [71:0] exp_win(input int ch, input int c, input int seed);
    logic [71:0] w;
    for (int r = 0; r < 3; r++)
      for (int j = 0; j < 3; j++)
        w[(3*r+j)*8 +: 8] = pv(ch, r, c + j, seed);
    return w;
  endfunction

  task automatic set_rows(input int seed);
    R_row0 = mk_row(0, 0, seed); R_row1 = mk_row(0, 1, seed); R_row2 = mk_row(0, 2, seed);
    G_row0 = mk_row(1, 0, seed); G_row1 = mk_row(1, 1, seed); G_row2 = mk_row(1, 2, seed);
    B_row0 = mk_row(2, 0, seed); B_row1 = mk_row(2, 1, seed); B_row2 = mk_row(2, 2, seed);
  endtask

  // Drives one row set, then consumes windows. stall_col/stall_len hold
  // win_ready low before that column; inject keeps row_valid high with other
  // data during SCAN; rst_col >= 0 pulses reset once that many windows passed.
  task automatic run_row(input int seed, input int stall_col, input int stall_len,
                         input bit inject, input int rst_col);
    int   budget, got, stalled, cyc, last_cyc;
    bit   done;
    exp_t e;
    @(negedge clk);
    set_rows(seed);
    row_valid = 1'b1;
    win_ready = 1'b1;
    budget = 0;
    #1;
    while (!row_ready && budget < 20) begin
      @(negedge clk); #1;
      budget++;
    end
    if (!row_ready) begin
      tests++; fails++;
      $display("FAIL row_handshake_timeout seed=%0d row_ready=%b required=1", seed, row_ready);
      row_valid = 1'b0;
      return;
    end
    for (int c = 0; c < W; c++) begin
      e.col  = 9'(c);
      e.row  = 9'(exp_row);
      e.r    = exp_win(0, c, seed);
      e.g    = exp_win(1, c, seed);
      e.b    = exp_win(2, c, seed);
      e.last = (c == W - 1);
      e.fl   = (c == W - 1) && (exp_row == H - 1);
      sb.push_back(e);
    end
    @(negedge clk);
    got = 0; stalled = 0; cyc = 0; done = 1'b0; last_cyc = -1;
    while (!done && cyc < W + stall_len + 20) begin
      if (rst_col >= 0 && got == rst_col) begin
        rst = 1'b1;
        row_valid = 1'b0;
        win_ready = 1'b1;
        @(negedge clk); #1;
        tests++;
        if ({win_valid, row_ready, win_col, win_row, win_last, frame_last, win_R, win_G, win_B} !== '0) begin
          fails++;
          $display("FAIL reset_mid_scan valid=%b ready=%b col=%0d row=%0d R=%h required all zero",
                   win_valid, row_ready, win_col, win_row, win_R);
        end
        rst = 1'b0;
        sb.delete();
        exp_row = 0;
        for (int k = 0; k < 3; k++) begin
          #1;
          tests++;
          if ({win_valid, row_ready, win_col, win_row} !== {1'b0, 1'b1, 18'd0}) begin
            fails++;
            $display("FAIL after_reset_idle k=%0d valid=%b ready=%b col=%0d row=%0d required 0/1/0/0",
                     k, win_valid, row_ready, win_col, win_row);
          end
          @(negedge clk);
        end
        return;
      end
      if (inject) begin
        set_rows(seed + 100);
        row_valid = 1'b1;
      end else begin
        row_valid = 1'b0;
      end
      win_ready = !(got == stall_col && stalled < stall_len);
      #1;
      if (cyc == 0) begin
        tests++;
        if (win_valid !== 1'b1) begin
          fails++;
          $display("FAIL first_window_latency win_valid=%b required=1", win_valid);
        end
      end
      if (inject) begin
        tests++;
        if (row_ready !== 1'b0) begin
          fails++;
          $display("FAIL row_ready_in_scan got=%b required=0", row_ready);
        end
      end
      if (win_valid !== 1'b1) begin
        tests++; fails++;
        $display("FAIL window_gap cyc=%0d win_valid=%b required=1", cyc, win_valid);
      end else if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL extra_window col=%0d required no window", win_col);
      end else begin
        e = sb[0];
        tests++;
        if ({win_col, win_row, win_R, win_G, win_B, win_last, frame_last} !== e) begin
          fails++;
          $display("FAIL window seed=%0d ready=%b got=%h required=%h", seed, win_ready,
                   {win_col, win_row, win_R, win_G, win_B, win_last, frame_last}, e);
        end
        if (win_ready) begin
          void'(sb.pop_front());
          if (seed == 0 && e.col == 9'd5) begin
            tests++;
            if (win_R !== COL5_R) begin
              fails++;
              $display("FAIL ramp_col5 win_R=%h required=%h", win_R, COL5_R);
            end
          end
          got++;
          if (got == W) begin
            done = 1'b1;
            last_cyc = cyc;
          end
        end else begin
          stalled++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL row_timeout seed=%0d windows=%0d required=%0d", seed, got, W);
      sb.delete();
      return;
    end
    tests++;
    if (last_cyc != W - 1 + stall_len) begin
      fails++;
      $display("FAIL throughput seed=%0d last_window_cycle=%0d required=%0d", seed, last_cyc, W - 1 + stall_len);
    end
    row_valid = 1'b0;
    #1;
    tests++;
    if ({win_valid, row_ready} !== 2'b01) begin
      fails++;
      $display("FAIL after_last valid=%b ready=%b required valid=0 ready=1", win_valid, row_ready);
    end
    exp_row = (exp_row + 1) % H;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    row_valid = 1'b0; win_ready = 1'b1; set_rows(0);
    s_row_valid = 1'b0; s_win_ready = 1'b1;
    {s_R_row0, s_G_row0, s_B_row0, s_R_row1, s_G_row1, s_B_row1, s_R_row2, s_G_row2, s_B_row2} = '0;
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if ({row_ready, win_valid, s_row_ready, s_win_valid} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_held row_ready=%b win_valid=%b required 0/0", row_ready, win_valid);
    end
    rst = 1'b0;
    #1;
    tests++;
    if ({row_ready, win_valid, win_row, win_col, win_last, frame_last, win_R, win_G, win_B}
        !== {1'b1, 1'b0, 9'd0, 9'd0, 1'b0, 1'b0, 216'd0}) begin
      fails++;
      $display("FAIL reset_release ready=%b valid=%b row=%0d col=%0d R=%h required 1/0/0/0/0",
               row_ready, win_valid, win_row, win_col, win_R);
    end
  endtask

  task automatic test_ramp();
    run_row(0, -1, 0, 1'b0, -1);
  endtask

  task automatic test_backpressure();
    run_row(1, 100, 10, 1'b0, -1);
  endtask

  task automatic test_ignore_row_valid();
    run_row(2, -1, 0, 1'b1, -1);
  endtask

  task automatic test_reset_mid();
    run_row(3, -1, 0, 1'b0, 200);
    run_row(4, -1, 0, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    run_row(5, 7, 2, 1'b0, -1);
    run_row(6, -1, 0, 1'b0, -1);
  endtask

  task automatic test_small_frame();
    int fl_cnt, budget;
    fl_cnt = 0;
    s_win_ready = 1'b1;
    for (int rs = 0; rs < 5; rs++) begin
      @(negedge clk);
      for (int p = 0; p < SW + 2; p++) begin
        s_R_row0[p*8 +: 8] = pv(0, 0, p, rs + 7);
        s_R_row1[p*8 +: 8] = pv(0, 1, p, rs + 7);
        s_R_row2[p*8 +: 8] = pv(0, 2, p, rs + 7);
        s_G_row0[p*8 +: 8] = pv(1, 0, p, rs + 7);
        s_G_row1[p*8 +: 8] = pv(1, 1, p, rs + 7);
        s_G_row2[p*8 +: 8] = pv(1, 2, p, rs + 7);
        s_B_row0[p*8 +: 8] = pv(2, 0, p, rs + 7);
        s_B_row1[p*8 +: 8] = pv(2, 1, p, rs + 7);
        s_B_row2[p*8 +: 8] = pv(2, 2, p, rs + 7);
      end
      s_row_valid = 1'b1;
      budget = 0;
      #1;
      while (!s_row_ready && budget < 20) begin
        @(negedge clk); #1;
        budget++;
      end
      if (!s_row_ready) begin
        tests++; fails++;
        $display("FAIL small_handshake_timeout set=%0d row_ready=%b required=1", rs, s_row_ready);
        s_row_valid = 1'b0;
        return;
      end
      @(negedge clk);
      s_row_valid = 1'b0;
      for (int c = 0; c < SW; c++) begin
        #1;
        tests++;
        if ({s_win_valid, s_win_col, s_win_row, s_win_R, s_win_B, s_win_last, s_frame_last}
            !== {1'b1, 9'(c), 9'(rs % SH), exp_win(0, c, rs + 7), exp_win(2, c, rs + 7),
                 (c == SW - 1), (c == SW - 1) && (rs % SH == SH - 1)}) begin
          fails++;
          $display("FAIL small_window set=%0d col=%0d got valid=%b col=%0d row=%0d last=%b fl=%b R=%h",
                   rs, c, s_win_valid, s_win_col, s_win_row, s_win_last, s_frame_last, s_win_R);
        end
        if (s_frame_last === 1'b1) fl_cnt++;
        @(negedge clk);
      end
      if (rs == SH - 1) begin
        #1;
        tests++;
        if ({s_win_valid, s_win_row} !== {1'b0, 9'd0}) begin
          fails++;
          $display("FAIL small_row_wrap valid=%b row=%0d required valid=0 row=0", s_win_valid, s_win_row);
        end
      end
    end
    tests++;
    if (fl_cnt != 1) begin
      fails++;
      $display("FAIL frame_last_count got=%0d required=1", fl_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_backpressure();
    test_ignore_row_valid();
    test_reset_mid();
    test_back_to_back();
    test_small_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
